// File: rtl/mac_array_engine.sv
// mac_array_engine: four-column signed dot-product engine with accumulation
// over ACC_LEN input vectors and an M-entry result buffer that is read
// asynchronously.
// Optional build macro ACC_RELU_EN: when defined, negative column sums are
// stored as zero in the result buffer.
module mac_array_engine #(
  parameter int M       = 16,
  parameter int ACC_LEN = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   isNewDin,
  input  logic                   isNewWtin,
  input  logic [255:0]           din,
  input  logic [1023:0]          wtin,
  input  logic [$clog2(M)-1:0]   addrDout,
  output logic [187:0]           dout,
  output logic                   busy,
  output logic [$clog2(M)-1:0]   wr_ptr,
  output logic                   overrun
);

  typedef enum logic [1:0] {IDLE, MAC, WRITE} state_t;

  state_t                 state_q;
  logic                   din_hist_q, wt_hist_q;
  logic [255:0]           xreg_q, xpend_q;
  logic [1023:0]          wreg_q, wpend_q;
  logic                   din_pend_q, wt_pend_q;
  logic signed [46:0]     acc_q [4];
  logic signed [46:0]     acc_d [4];
  logic [4:0]             vec_cnt_q;
  logic [3:0]             k_q;
  logic [$clog2(M)-1:0]   wr_ptr_q;
  logic                   overrun_q;
  logic [187:0]           mem_q [M];
  logic [187:0]           wr_word_d;

  logic din_ev, wt_ev, in_idle;
  logic start_from_pend, start_from_din, mac_start;

  // 16x16 signed product, sign-extended to the accumulator width
  function automatic logic signed [46:0] mac_prod(input logic signed [15:0] a,
                                                  input logic signed [15:0] b);
    logic signed [31:0] p;
    p = a * b;
    return {{15{p[31]}}, p};
  endfunction

  // Value written to the buffer for one column
  function automatic logic [46:0] store_col(input logic signed [46:0] v);
`ifdef ACC_RELU_EN
    return v[46] ? 47'd0 : v;
`else
    return v;
`endif
  endfunction

  assign din_ev  = isNewDin ^ din_hist_q;
  assign wt_ev   = isNewWtin ^ wt_hist_q;
  assign in_idle = (state_q == IDLE);

  // Pending weights always go in before any vector starts; a vector arriving
  // together with new weights waits one cycle so it sees them.
  assign start_from_pend = in_idle && !wt_pend_q && din_pend_q;
  assign start_from_din  = in_idle && !wt_pend_q && !wt_ev && !din_pend_q && din_ev;
  assign mac_start       = start_from_pend || start_from_din;

  // Per-column multiply-accumulate for element k (wraps mod 2^47)
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      acc_d[c] = acc_q[c] + mac_prod(xreg_q[16*k_q +: 16],
                                     wreg_q[16*(16*c + int'(k_q)) +: 16]);
    end
  end

  // Packed result word, column 0 in the low bits
  always_comb begin
    wr_word_d = {store_col(acc_q[3]), store_col(acc_q[2]),
                 store_col(acc_q[1]), store_col(acc_q[0])};
  end

  // Handshake tracking, operand capture, FSM and result buffer
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      din_hist_q <= isNewDin;
      wt_hist_q  <= isNewWtin;
      din_pend_q <= 1'b0;
      wt_pend_q  <= 1'b0;
      vec_cnt_q  <= '0;
      k_q        <= '0;
      wr_ptr_q   <= '0;
      overrun_q  <= 1'b0;
      for (int c = 0; c < 4; c++) acc_q[c] <= '0;
      for (int i = 0; i < M; i++) mem_q[i] <= '0;
    end else begin
      din_hist_q <= isNewDin;
      wt_hist_q  <= isNewWtin;

      if (wt_ev) begin
        if (in_idle && !mac_start) begin
          wreg_q    <= wtin;
          wt_pend_q <= 1'b0;
        end else begin
          wpend_q   <= wtin;
          wt_pend_q <= 1'b1;
        end
      end else if (in_idle && wt_pend_q) begin
        wreg_q    <= wpend_q;
        wt_pend_q <= 1'b0;
      end

      if (start_from_pend) begin
        xreg_q     <= xpend_q;
        din_pend_q <= 1'b0;
      end
      if (din_ev) begin
        if (start_from_din) begin
          xreg_q <= din;
        end else if (!din_pend_q) begin
          xpend_q    <= din;
          din_pend_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (mac_start) begin
            state_q <= MAC;
            k_q     <= '0;
          end
        end
        MAC: begin
          for (int c = 0; c < 4; c++) acc_q[c] <= acc_d[c];
          k_q <= k_q + 4'd1;
          if (k_q == 4'd15) begin
            vec_cnt_q <= vec_cnt_q + 5'd1;
            state_q   <= (vec_cnt_q == 5'(ACC_LEN - 1)) ? WRITE : IDLE;
          end
        end
        WRITE: begin
          mem_q[wr_ptr_q] <= wr_word_d;
          wr_ptr_q        <= wr_ptr_q + 1'b1;
          vec_cnt_q       <= '0;
          for (int c = 0; c < 4; c++) acc_q[c] <= '0;
          state_q         <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout    = mem_q[addrDout];
  assign busy    = !in_idle || din_pend_q || wt_pend_q;
  assign wr_ptr  = wr_ptr_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_mac_array_engine.sv
// Directed bench for mac_array_engine: two instances share the stimulus,
// one accumulating a single vector per result and one accumulating four.
module tb_mac_array_engine;

`ifdef ACC_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          isNewDin, isNewWtin;
  logic [255:0]  din;
  logic [1023:0] wtin;
  logic [3:0]    addrDout;
  logic [187:0]  dout1, dout4;
  logic          busy1, busy4, ovr1, ovr4;
  logic [3:0]    wp1, wp4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mac_array_engine #(.M(16), .ACC_LEN(1)) u_acc1 (
    .clk(clk), .reset_n(reset_n), .isNewDin(isNewDin), .isNewWtin(isNewWtin),
    .din(din), .wtin(wtin), .addrDout(addrDout), .dout(dout1),
    .busy(busy1), .wr_ptr(wp1), .overrun(ovr1));

  mac_array_engine #(.M(16), .ACC_LEN(4)) u_acc4 (
    .clk(clk), .reset_n(reset_n), .isNewDin(isNewDin), .isNewWtin(isNewWtin),
    .din(din), .wtin(wtin), .addrDout(addrDout), .dout(dout4),
    .busy(busy4), .wr_ptr(wp4), .overrun(ovr4));

  task automatic check_eq(input string tag, input logic [187:0] got,
                          input logic [187:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_din(input logic [15:0] e);
    din      = {16{e}};
    isNewDin = ~isNewDin;
    tick();
  endtask

  task automatic send_wt4(input logic [15:0] w0, input logic [15:0] w1,
                          input logic [15:0] w2, input logic [15:0] w3);
    wtin      = {{16{w3}}, {16{w2}}, {16{w1}}, {16{w0}}};
    isNewWtin = ~isNewWtin;
    tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  function automatic logic [187:0] cols(input longint c0, input longint c1,
                                        input longint c2, input longint c3);
    return {c3[46:0], c2[46:0], c1[46:0], c0[46:0]};
  endfunction

  function automatic logic [187:0] relu_cols(input longint c0, input longint c1,
                                             input longint c2, input longint c3);
    return {(c3 < 0 && RELU) ? 47'd0 : c3[46:0], (c2 < 0 && RELU) ? 47'd0 : c2[46:0],
            (c1 < 0 && RELU) ? 47'd0 : c1[46:0], (c0 < 0 && RELU) ? 47'd0 : c0[46:0]};
  endfunction

  task automatic check_mem(input string tag, input logic [3:0] addr,
                           input bit use4, input logic [187:0] exp);
    addrDout = addr;
    #1;
    check_eq(tag, use4 ? dout4 : dout1, exp);
  endtask

  initial begin
    reset_n   = 1'b0;
    isNewDin  = 1'b1;
    isNewWtin = 1'b1;
    din       = '0;
    wtin      = '0;
    addrDout  = '0;

    // Reset with both toggles high; no event may fire on release
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    check_eq("rst_dout", dout1, '0);
    check_eq("rst_wrptr", 188'(wp1), '0);
    check_eq("rst_busy", 188'(busy1), '0);
    check_eq("rst_ovr", 188'(ovr1), '0);
    repeat (3) tick();
    check_eq("rst_no_event_busy1", 188'(busy1), '0);
    check_eq("rst_no_event_busy4", 188'(busy4), '0);

    // Single-vector result: weights 1, elements 2 -> 32 per column
    send_wt4(16'd1, 16'd1, 16'd1, 16'd1);
    send_din(16'd2);
    repeat (16) tick();
    check_eq("lat_pre_write_dout", dout1, '0);
    check_eq("lat_pre_write_busy", 188'(busy1), 188'd1);
    tick();
    check_eq("lat_write_dout", dout1, cols(32, 32, 32, 32));
    check_eq("lat_write_wrptr", 188'(wp1), 188'd1);
    check_eq("acc4_no_write_yet", 188'(wp4), '0);
    tick();
    check_eq("idle_busy", 188'(busy1), '0);

    // Negative elements, column weights c+1
    do_reset();
    send_wt4(16'd1, 16'd2, 16'd3, 16'd4);
    for (int v = 0; v < 4; v++) begin
      send_din(16'hFFFF);
      repeat (18) tick();
    end
    check_mem("neg_acc1_e0", 4'd0, 1'b0, relu_cols(-16, -32, -48, -64));
    check_mem("neg_acc1_e3", 4'd3, 1'b0, relu_cols(-16, -32, -48, -64));
    check_eq("neg_acc1_wrptr", 188'(wp1), 188'd4);
    check_mem("neg_acc4_e0", 4'd0, 1'b1, relu_cols(-64, -128, -192, -256));
    check_eq("neg_acc4_wrptr", 188'(wp4), 188'd1);

    // Three vectors during one MAC: first runs, second pends, third drops
    do_reset();
    send_wt4(16'd1, 16'd1, 16'd1, 16'd1);
    send_din(16'd1);
    tick();
    send_din(16'd2);
    tick();
    send_din(16'd3);
    check_eq("ovr_set1", 188'(ovr1), 188'd1);
    check_eq("ovr_set4", 188'(ovr4), 188'd1);
    repeat (40) tick();
    check_mem("ovr_first", 4'd0, 1'b0, cols(16, 16, 16, 16));
    check_mem("ovr_second", 4'd1, 1'b0, cols(32, 32, 32, 32));
    check_mem("ovr_dropped", 4'd2, 1'b0, '0);
    check_eq("ovr_wrptr", 188'(wp1), 188'd2);
    check_eq("ovr_sticky", 188'(ovr1), 188'd1);
    check_eq("ovr_busy_done", 188'(busy1), '0);

    // Weights changed mid-MAC apply only to the next vector
    do_reset();
    check_eq("ovr_cleared", 188'(ovr1), '0);
    send_wt4(16'd1, 16'd1, 16'd1, 16'd1);
    send_din(16'd1);
    tick();
    send_wt4(16'd2, 16'd3, 16'd4, 16'd5);
    send_din(16'd1);
    repeat (45) tick();
    check_mem("wt_old", 4'd0, 1'b0, cols(16, 16, 16, 16));
    check_mem("wt_new", 4'd1, 1'b0, cols(32, 48, 64, 80));
    check_eq("wt_wrptr", 188'(wp1), 188'd2);

    // Extreme operands and buffer wrap
    do_reset();
    send_wt4(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    for (int v = 0; v < 16; v++) begin
      send_din(16'h8000);
      repeat (18) tick();
    end
    check_eq("wrap_wrptr_16", 188'(wp1), '0);
    check_mem("ext_acc1_e15", 4'd15, 1'b0, cols(64'sd1 << 34, 64'sd1 << 34,
                                                64'sd1 << 34, 64'sd1 << 34));
    check_mem("ext_acc4_e0", 4'd0, 1'b1, cols(64'sd1 << 36, 64'sd1 << 36,
                                              64'sd1 << 36, 64'sd1 << 36));
    send_din(16'd1);
    repeat (18) tick();
    check_eq("wrap_wrptr_17", 188'(wp1), 188'd1);
    check_mem("wrap_overwrite_e0", 4'd0, 1'b0,
              relu_cols(-524288, -524288, -524288, -524288));
    check_mem("wrap_keep_e1", 4'd1, 1'b0, cols(64'sd1 << 34, 64'sd1 << 34,
                                               64'sd1 << 34, 64'sd1 << 34));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
